// File: rtl/pwm_pkg.sv
// Shared constants for the PWM bank: CTRL bit positions and register-map helpers.
package pwm_pkg;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_FADE   = 1;
  localparam int CTRL_BITS   = 2;
  localparam int STATUS_BUSY = 0;

  // CTRL sits right after the per-channel TARGET registers, STATUS after CTRL.
  function automatic int addr_ctrl(input int channels);
    return channels;
  endfunction

  function automatic int addr_status(input int channels);
    return channels + 1;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM lane: TARGET register, CUR shadow duty (loaded/faded at wrap), registered compare.
module pwm_channel #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] cnt,
  input  logic             wrap,
  input  logic             en,
  input  logic             fade_en,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] target,
  output logic             busy,
  output logic             pwm
);

  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic             pwm_q, pwm_d;

  always_comb begin
    target_d = wr ? wr_data : target_q;
    cur_d    = cur_q;
    // Disabled lanes track TARGET directly; enabled lanes only move at the wrap edge,
    // which also sees the pre-write TARGET if a write lands in the same cycle.
    if (!en) begin
      cur_d = target_q;
    end else if (wrap) begin
      if (!fade_en)              cur_d = target_q;
      else if (cur_q < target_q) cur_d = cur_q + 1'b1;
      else if (cur_q > target_q) cur_d = cur_q - 1'b1;
    end
    pwm_d = en && (cnt < cur_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_q <= '0;
      cur_q    <= '0;
      pwm_q    <= 1'b0;
    end else begin
      target_q <= target_d;
      cur_q    <= cur_d;
      pwm_q    <= pwm_d;
    end
  end

  assign target = target_q;
  assign busy   = (cur_q != target_q);
  assign pwm    = pwm_q;

endmodule

// File: rtl/pwm_bank.sv
// N-channel PWM bank: shared prescaler and period counter, CTRL/STATUS registers, read mux.
module pwm_bank
  import pwm_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 47,
  parameter int ADDR_W   = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [WIDTH-1:0]    wr_data,
  output logic [WIDTH-1:0]    rd_data,
  output logic                rd_valid,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_start
);

  localparam int                PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]     PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0]  CNT_LAST   = {{(WIDTH-1){1'b1}}, 1'b0};
  localparam logic [ADDR_W-1:0] A_CTRL     = ADDR_W'(addr_ctrl(CHANNELS));
  localparam logic [ADDR_W-1:0] A_STATUS   = ADDR_W'(addr_status(CHANNELS));

  logic [PW-1:0]              presc_q, presc_d;
  logic [WIDTH-1:0]           cnt_q, cnt_d;
  logic [CTRL_BITS-1:0]       ctrl_q, ctrl_d;
  logic                       ps_q, ps_d;
  logic [WIDTH-1:0]           rd_data_q, rd_data_d;
  logic                       rd_valid_q, rd_valid_d;

  logic                       en, tick, wrap;
  logic [CHANNELS-1:0]        ch_wr, busy;
  logic [CHANNELS-1:0][WIDTH-1:0] tgt;

  assign en   = ctrl_q[CTRL_EN];
  assign tick = en && (presc_q == PRESC_LAST);
  assign wrap = tick && (cnt_q == CNT_LAST);

  always_comb begin
    presc_d = '0;
    cnt_d   = '0;
    if (en) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      cnt_d   = cnt_q;
      if (tick) cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end

    ctrl_d = ctrl_q;
    if (wr_en && addr == A_CTRL) ctrl_d = wr_data[CTRL_BITS-1:0];

    ps_d = wrap;

    // A simultaneous write suppresses the read entirely.
    rd_valid_d = rd_en && !wr_en;
    rd_data_d  = rd_data_q;
    if (rd_valid_d) begin
      rd_data_d = '0;
      for (int i = 0; i < CHANNELS; i++)
        if (addr == ADDR_W'(i)) rd_data_d = tgt[i];
      if (addr == A_CTRL)   rd_data_d[CTRL_BITS-1:0] = ctrl_q;
      if (addr == A_STATUS) rd_data_d[STATUS_BUSY]   = |busy;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      cnt_q      <= '0;
      ctrl_q     <= '0;
      ps_q       <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      cnt_q      <= cnt_d;
      ctrl_q     <= ctrl_d;
      ps_q       <= ps_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    assign ch_wr[g] = wr_en && (addr == ADDR_W'(g));

    pwm_channel #(.WIDTH(WIDTH)) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .cnt     (cnt_q),
      .wrap    (wrap),
      .en      (en),
      .fade_en (ctrl_q[CTRL_FADE]),
      .wr      (ch_wr[g]),
      .wr_data (wr_data),
      .target  (tgt[g]),
      .busy    (busy[g]),
      .pwm     (pwm_out[g])
    );
  end

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign period_start = ps_q;

endmodule

// File: tb/tb_pwm_bank.sv
// Directed bench for pwm_bank (8 channels, 8-bit, PRESCALE=1): bus table plus period-level sequences.
module tb_pwm_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en, rd_en;
  logic [4:0] addr;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [7:0] pwm_out;
  logic       period_start;

  int vec_cnt = 0;
  int err_cnt = 0;
  int hi[8];

  typedef struct {
    bit         wr;
    bit         rd;
    logic [4:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t tbl[17];

  pwm_bank #(.CHANNELS(8), .WIDTH(8), .PRESCALE(1), .ADDR_W(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .addr         (addr),
    .wr_data      (wr_data),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // All tasks are entered and left on a falling edge.
  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    addr = a; wr_data = d; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [7:0] d);
    addr = a; rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check("rd_valid", rd_valid, 1);
    d = rd_data;
    @(negedge clk);
    check("rd_valid_1clk", rd_valid, 0);
  endtask

  task automatic wait_ps();
    int k = 0;
    while (!period_start && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("wait_ps", period_start, 1);
  endtask

  // Samples the 255 cycles following a period_start: they reflect cnt = 0..254.
  task automatic measure();
    for (int c = 0; c < 8; c++) hi[c] = 0;
    for (int k = 0; k < 255; k++) begin
      @(negedge clk);
      for (int c = 0; c < 8; c++) hi[c] += int'(pwm_out[c]);
    end
  endtask

  task automatic run_to_ps(input int ch, output int k, output int h);
    k = 0; h = 0;
    while (!period_start && k < 1000) begin
      @(negedge clk);
      k++;
      h += int'(pwm_out[ch]);
    end
  endtask

  initial begin
    logic [7:0] d;
    int k, h, pcnt;

    tbl[0]  = '{0, 1, 5'd0,  8'h00, 8'h00, "tgt0_reset"};
    tbl[1]  = '{0, 1, 5'd8,  8'h00, 8'h00, "ctrl_reset"};
    tbl[2]  = '{0, 1, 5'd9,  8'h00, 8'h00, "status_reset"};
    tbl[3]  = '{1, 0, 5'd8,  8'hFF, 8'h00, "wr_ctrl_ff"};
    tbl[4]  = '{0, 1, 5'd8,  8'h00, 8'h03, "ctrl_mask"};
    tbl[5]  = '{1, 0, 5'd8,  8'h00, 8'h00, "wr_ctrl_0"};
    tbl[6]  = '{1, 0, 5'd0,  8'hAA, 8'h00, "wr_tgt0"};
    tbl[7]  = '{0, 1, 5'd0,  8'h00, 8'hAA, "tgt0_rb"};
    tbl[8]  = '{1, 0, 5'd7,  8'h5A, 8'h00, "wr_tgt7"};
    tbl[9]  = '{0, 1, 5'd7,  8'h00, 8'h5A, "tgt7_rb"};
    tbl[10] = '{1, 0, 5'd31, 8'h55, 8'h00, "wr_addr31"};
    tbl[11] = '{0, 1, 5'd31, 8'h00, 8'h00, "rd_addr31"};
    tbl[12] = '{0, 1, 5'd0,  8'h00, 8'hAA, "tgt0_after31"};
    tbl[13] = '{0, 1, 5'd8,  8'h00, 8'h00, "ctrl_after31"};
    tbl[14] = '{0, 1, 5'd10, 8'h00, 8'h00, "rd_addr10"};
    tbl[15] = '{1, 0, 5'd0,  8'h00, 8'h00, "clr_tgt0"};
    tbl[16] = '{1, 0, 5'd7,  8'h00, 8'h00, "clr_tgt7"};

    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    check("rst_pwm", pwm_out, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_ps", period_start, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 17; i++) begin
      if (tbl[i].wr) wr(tbl[i].addr, tbl[i].data);
      if (tbl[i].rd) begin
        rd(tbl[i].addr, d);
        check(tbl[i].name, d, tbl[i].exp);
      end
    end

    // Read data holds; a combined write+read writes and does not read.
    wr(5'd2, 8'h77);
    rd(5'd2, d);
    check("rd_77", d, 8'h77);
    repeat (5) @(negedge clk);
    check("rd_hold", rd_data, 8'h77);
    addr = 5'd2; wr_data = 8'h33; wr_en = 1'b1; rd_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    check("wr_rd_no_valid", rd_valid, 0);
    check("wr_rd_hold", rd_data, 8'h77);
    rd(5'd2, d);
    check("wr_rd_wrote", d, 8'h33);

    // Duty cycles, and the first period after enable.
    wr(5'd0, 8'd64);
    wr(5'd1, 8'd0);
    wr(5'd2, 8'd255);
    wr(5'd8, 8'h01);
    check("no_ps_on_en", period_start, 0);
    run_to_ps(0, k, h);
    check("first_period_len", k, 255);
    check("first_period_duty0", h, 64);
    measure();
    check("duty64", hi[0], 64);
    check("duty0", hi[1], 0);
    check("duty255", hi[2], 255);

    // Mid-period TARGET write waits for the next wrap.
    repeat (50) @(negedge clk);
    wr(5'd3, 8'd200);
    run_to_ps(3, k, h);
    check("db_ps", period_start, 1);
    check("db_old_duty", h, 0);
    measure();
    check("db_new_duty", hi[3], 200);

    // TARGET write landing on the wrap edge applies one period later.
    repeat (254) @(negedge clk);
    wr(5'd4, 8'd200);
    check("wrap_write_ps", period_start, 1);
    measure();
    check("wrap_write_old", hi[4], 0);
    measure();
    check("wrap_write_new", hi[4], 200);

    // Fade 10 -> 13 one step per period, then down to 0 without underflow.
    wr(5'd0, 8'd10);
    wait_ps();
    wr(5'd8, 8'h03);
    wr(5'd0, 8'd13);
    rd(5'd9, d);
    check("status_busy", d, 8'h01);
    wait_ps();
    for (int e = 11; e <= 13; e++) begin
      measure();
      check("fade_up", hi[0], e);
    end
    rd(5'd9, d);
    check("status_idle", d, 8'h00);
    wr(5'd0, 8'd0);
    wait_ps();
    for (int e = 12; e >= 0; e--) begin
      measure();
      check("fade_down", hi[0], e);
    end
    measure();
    check("fade_floor", hi[0], 0);

    // Disable mid-period, then re-enable.
    wr(5'd8, 8'h01);
    wr(5'd5, 8'd100);
    wait_ps();
    repeat (10) @(negedge clk);
    check("ch5_high", pwm_out[5], 1);
    wr(5'd8, 8'h00);
    @(negedge clk);
    check("dis_pwm", pwm_out, 0);
    wr(5'd5, 8'd30);
    @(negedge clk);
    rd(5'd9, d);
    check("dis_cur_eq_tgt", d, 8'h00);
    pcnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      pcnt += int'(period_start);
    end
    check("dis_no_ps", pcnt, 0);
    check("dis_pwm_hold", pwm_out, 0);
    wr(5'd8, 8'h01);
    check("reen_no_ps", period_start, 0);
    run_to_ps(5, k, h);
    check("reen_period_len", k, 255);
    check("reen_duty30", h, 30);

    // Asynchronous reset mid-run.
    rd(5'd2, d);
    check("pre_rst_rd", d, 8'd255);
    check("pre_rst_pwm2", pwm_out[2], 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_pwm", pwm_out, 0);
    check("async_rd_data", rd_data, 0);
    check("async_rd_valid", rd_valid, 0);
    check("async_ps", period_start, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      rd(5'(i), d);
      check("post_rst_reg", d, 0);
    end
    check("post_rst_pwm", pwm_out, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
